// File: rtl/axil_master_pkg.sv
// Shared types and AXI response codes for the AXI4-Lite configuration master.
package axil_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

endpackage

// File: rtl/axil_cfg_master.sv
// AXI4-Lite master: one register command in, one AXI transaction out, one response back.
// Every channel uses valid/ready: a transfer happens on a clock edge where both are high,
// and a valid, once raised, holds with stable payload until that transfer.
module axil_cfg_master
  import axil_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 13,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [2:0]            dbg_state,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          expire, tmo_hit, aw_left, w_left;

  assign cmd_ready = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    tmo_hit = 1'b0;
    aw_left = awvalid && !awready;
    w_left  = wvalid && !wready;
    expire  = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    case (state)
      IDLE:    if (cmd_valid) state_n = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ: begin
        if (!aw_left && !w_left) state_n = WR_RESP;
        else if (expire) begin state_n = RSP; tmo_hit = 1'b1; end
      end
      WR_RESP: begin
        if (bvalid) state_n = RSP;
        else if (expire) begin state_n = RSP; tmo_hit = 1'b1; end
      end
      RD_REQ: begin
        if (arready) state_n = RD_RESP;
        else if (expire) begin state_n = RSP; tmo_hit = 1'b1; end
      end
      RD_RESP: begin
        if (rvalid) state_n = RSP;
        else if (expire) begin state_n = RSP; tmo_hit = 1'b1; end
      end
      RSP:     if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Cycles spent in the current wait state; restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (state_n != state) cnt <= '0;
    else if (state != IDLE && state != RSP && cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      arvalid     <= 1'b0;
      bready      <= 1'b0;
      rready      <= 1'b0;
      rsp_valid   <= 1'b0;
      busy        <= 1'b0;
      awaddr      <= '0;
      araddr      <= '0;
      wdata       <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= AXI_OKAY;
      rsp_timeout <= 1'b0;
    end else begin
      awvalid   <= (state_n == WR_REQ) && ((state == IDLE) || aw_left);
      wvalid    <= (state_n == WR_REQ) && ((state == IDLE) || w_left);
      arvalid   <= (state_n == RD_REQ);
      bready    <= (state_n == WR_RESP);
      rready    <= (state_n == RD_RESP);
      rsp_valid <= (state_n == RSP);
      busy      <= (state_n != IDLE);
      if (state == IDLE && cmd_valid) begin
        if (cmd_write) begin
          awaddr <= cmd_addr;
          wdata  <= cmd_wdata;
        end else begin
          araddr <= cmd_addr;
        end
        rsp_timeout <= 1'b0;
      end
      if (tmo_hit) begin
        rsp_timeout <= 1'b1;
        rsp_resp    <= AXI_SLVERR;
        rsp_rdata   <= '0;
      end else if (state == WR_RESP && bvalid) begin
        rsp_resp  <= bresp;
        rsp_rdata <= '0;
      end else if (state == RD_RESP && rvalid) begin
        rsp_resp  <= rresp;
        rsp_rdata <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_axil_cfg_master.sv
// Bench for axil_cfg_master: table of directed transactions against a delay-programmable slave,
// plus hand-written timeout and reset-abort sequences.
module tb_axil_cfg_master;
  localparam int AW  = 13;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [2:0]    dbg_state;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [1:0]    bresp, rresp;

  always #5 clk = ~clk;

  axil_cfg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy), .dbg_state(dbg_state),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- slave model (drives at negedge) ----------------
  int          s_aw_dly = 0, s_w_dly = 0, s_ar_dly = 0, s_b_dly = 0, s_r_dly = 0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = '0;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit          got_aw, got_w, got_ar, aw_hs, w_hs, ar_hs, b_hs, r_hs;

  initial begin
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    got_aw = 0; got_w = 0; got_ar = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
      end else begin
        if (aw_hs) got_aw = 1;
        if (w_hs)  got_w  = 1;
        if (ar_hs) got_ar = 1;
        if (b_hs) begin got_aw = 0; got_w = 0; bvalid = 0; b_cnt = 0; end
        if (r_hs) begin got_ar = 0; rvalid = 0; r_cnt = 0; end
        if (awvalid) begin awready = (aw_cnt >= s_aw_dly); aw_cnt++; end
        else begin awready = 0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt >= s_w_dly); w_cnt++; end
        else begin wready = 0; w_cnt = 0; end
        if (arvalid) begin arready = (ar_cnt >= s_ar_dly); ar_cnt++; end
        else begin arready = 0; ar_cnt = 0; end
        bresp = s_bresp;
        if (got_aw && got_w) begin bvalid = (b_cnt >= s_b_dly); b_cnt++; end
        if (got_ar) begin
          rvalid = (r_cnt >= s_r_dly); rdata = s_rdata; rresp = s_rresp; r_cnt++;
        end
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        ar_hs = arvalid && arready;
        b_hs  = bvalid && bready;
        r_hs  = rvalid && rready;
      end
    end
  end

  // ---------------- channel monitor (samples at posedge) ----------------
  int            aw_hi = 0, w_hi = 0, ar_hi = 0, b_hs_n = 0, r_hs_n = 0, viol = 0;
  bit            allow_drop = 0;
  logic          p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
  logic [DW-1:0] p_wdata = '0;

  always @(posedge clk) begin
    if (reset) begin
      p_awv <= 0; p_wv <= 0; p_arv <= 0;
    end else begin
      if (awvalid) aw_hi <= aw_hi + 1;
      if (wvalid)  w_hi  <= w_hi + 1;
      if (arvalid) ar_hi <= ar_hi + 1;
      if (bvalid && bready) b_hs_n <= b_hs_n + 1;
      if (rvalid && rready) r_hs_n <= r_hs_n + 1;
      if (p_awv && !p_awr && !allow_drop && (!awvalid || awaddr != p_awaddr)) viol <= viol + 1;
      if (p_wv  && !p_wr  && !allow_drop && (!wvalid  || wdata  != p_wdata))  viol <= viol + 1;
      if (p_arv && !p_arr && !allow_drop && (!arvalid || araddr != p_araddr)) viol <= viol + 1;
      p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
      p_wv  <= wvalid;  p_wr  <= wready;  p_wdata  <= wdata;
      p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
    end
  end

  // ---------------- driver ----------------
  logic          snap_awv, snap_wv, snap_arv;
  logic [AW-1:0] snap_awaddr, snap_araddr;
  logic [DW-1:0] snap_wdata;

  task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int hold, input string tag,
                         output logic [DW-1:0] rd, output logic [1:0] rs, output logic to,
                         output int lat);
    int n;
    int c0;
    rd = '0; rs = 2'b00; to = 1'b0; lat = -1;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("%s cmd_ready", tag), cmd_ready, 1);
    if (!cmd_ready) begin cmd_valid = 0; return; end
    c0 = cyc;
    @(negedge clk);
    cmd_valid = 0;
    snap_awv = awvalid; snap_wv = wvalid; snap_arv = arvalid;
    snap_awaddr = awaddr; snap_wdata = wdata; snap_araddr = araddr;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk($sformatf("%s rsp_valid", tag), rsp_valid, 1);
    if (!rsp_valid) return;
    lat = cyc - c0; rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("%s hold%0d flags", tag, i), {rsp_valid, rsp_timeout, cmd_ready, rsp_resp},
          {1'b1, to, 1'b0, rs});
      chk($sformatf("%s hold%0d rdata", tag, i), rsp_rdata, rd);
    end
    chk($sformatf("%s cmd_ready in RSP", tag), cmd_ready, 0);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk($sformatf("%s idle after rsp", tag), {cmd_ready, rsp_valid, busy}, 3'b100);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #2 reset = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata;
    int aw_dly; int w_dly; int ar_dly; int b_dly; int r_dly;
    logic [1:0] s_resp; logic [DW-1:0] s_rdata; int hold;
    logic [DW-1:0] exp_rdata; logic [1:0] exp_resp;
    int exp_lat; int exp_aw; int exp_w; int exp_ar;
  } vec_t;

  vec_t          vecs[8];
  vec_t          v;
  logic [DW-1:0] rd;
  logic [1:0]    rs;
  logic          to;
  int            lat, aw0, w0, ar0, b0, r0, v0, n;
  logic          q_wr[5];
  logic [AW-1:0] q_addr[5];
  logic [DW-1:0] q_data[5];

  initial begin
    //          wr  addr      wdata         aw w ar b r resp   s_rdata      hold exp_rdata    resp  lat aw w ar
    vecs[0] = '{1'b1, 13'h010, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, 32'h0,        0, 32'h0,        2'b00, 3, 1, 1, 0};
    vecs[1] = '{1'b0, 13'h020, 32'h0,        0, 0, 5, 0, 3, 2'b00, 32'h12345678, 0, 32'h12345678, 2'b00, 11, 0, 0, 6};
    vecs[2] = '{1'b1, 13'h044, 32'hA5A5A5A5, 4, 0, 0, 1, 0, 2'b00, 32'h0,        0, 32'h0,        2'b00, 8, 5, 1, 0};
    vecs[3] = '{1'b1, 13'h048, 32'h0000FFFF, 2, 2, 0, 0, 0, 2'b00, 32'h0,        0, 32'h0,        2'b00, 5, 3, 3, 0};
    vecs[4] = '{1'b1, 13'h04C, 32'h80000001, 0, 3, 0, 2, 0, 2'b00, 32'h0,        0, 32'h0,        2'b00, 8, 1, 4, 0};
    vecs[5] = '{1'b1, 13'h100, 32'h11223344, 0, 0, 0, 0, 0, 2'b10, 32'h0,        6, 32'h0,        2'b10, 3, 1, 1, 0};
    vecs[6] = '{1'b0, 13'h1FFC, 32'h0,       0, 0, 0, 0, 0, 2'b11, 32'hCAFEF00D, 0, 32'hCAFEF00D, 2'b11, 3, 0, 0, 1};
    vecs[7] = '{1'b0, 13'h004, 32'h0,        0, 0, 1, 0, 2, 2'b01, 32'h00000001, 0, 32'h00000001, 2'b01, 6, 0, 0, 2};

    // reset values
    @(negedge clk); @(negedge clk);
    chk("reset flags", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_timeout, busy, cmd_ready},
        9'b000000001);
    chk("reset addrs", {awaddr, araddr}, 26'h0);
    chk("reset wdata", wdata, 32'h0);
    chk("reset rsp", {rsp_resp, rsp_rdata[29:0]}, 32'h0);
    chk("reset state", dbg_state, 3'd0);
    @(posedge clk); #2 reset = 0;

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      s_aw_dly = v.aw_dly; s_w_dly = v.w_dly; s_ar_dly = v.ar_dly;
      s_b_dly = v.b_dly; s_r_dly = v.r_dly;
      s_bresp = v.s_resp; s_rresp = v.s_resp; s_rdata = v.s_rdata;
      aw0 = aw_hi; w0 = w_hi; ar0 = ar_hi; b0 = b_hs_n; r0 = r_hs_n; v0 = viol;
      run_cmd(v.wr, v.addr, v.wdata, v.hold, $sformatf("v%0d", i), rd, rs, to, lat);
      if (v.wr) begin
        chk($sformatf("v%0d aw/w valid c1", i), {snap_awv, snap_wv, snap_arv}, 3'b110);
        chk($sformatf("v%0d awaddr c1", i), snap_awaddr, v.addr);
        chk($sformatf("v%0d wdata c1", i), snap_wdata, v.wdata);
      end else begin
        chk($sformatf("v%0d ar valid c1", i), {snap_awv, snap_wv, snap_arv}, 3'b001);
        chk($sformatf("v%0d araddr c1", i), snap_araddr, v.addr);
      end
      chk($sformatf("v%0d rdata", i), rd, v.exp_rdata);
      chk($sformatf("v%0d resp", i), rs, v.exp_resp);
      chk($sformatf("v%0d timeout", i), to, 0);
      chk($sformatf("v%0d latency", i), lat, v.exp_lat);
      chk($sformatf("v%0d aw cycles", i), aw_hi - aw0, v.exp_aw);
      chk($sformatf("v%0d w cycles", i), w_hi - w0, v.exp_w);
      chk($sformatf("v%0d ar cycles", i), ar_hi - ar0, v.exp_ar);
      chk($sformatf("v%0d B count", i), b_hs_n - b0, v.wr ? 1 : 0);
      chk($sformatf("v%0d R count", i), r_hs_n - r0, v.wr ? 0 : 1);
      chk($sformatf("v%0d stability", i), viol - v0, 0);
    end

    // read timeout: arready never comes
    allow_drop = 1;
    s_aw_dly = 0; s_w_dly = 0; s_ar_dly = 1000; s_b_dly = 0; s_r_dly = 0;
    ar0 = ar_hi; r0 = r_hs_n;
    run_cmd(1'b0, 13'h030, 32'h0, 0, "tmo_rd", rd, rs, to, lat);
    chk("tmo_rd timeout", to, 1);
    chk("tmo_rd resp", rs, 2'b10);
    chk("tmo_rd rdata", rd, 32'h0);
    chk("tmo_rd latency", lat, 9);
    chk("tmo_rd ar cycles", ar_hi - ar0, 8);
    chk("tmo_rd R count", r_hs_n - r0, 0);
    allow_drop = 0;

    // write timeout: bvalid never comes
    s_ar_dly = 0; s_b_dly = 1000;
    b0 = b_hs_n;
    run_cmd(1'b1, 13'h034, 32'h77777777, 0, "tmo_wr", rd, rs, to, lat);
    chk("tmo_wr timeout", to, 1);
    chk("tmo_wr resp", rs, 2'b10);
    chk("tmo_wr latency", lat, 10);
    chk("tmo_wr B count", b_hs_n - b0, 0);
    do_reset();

    // reset while waiting in WR_RESP
    b0 = b_hs_n; r0 = r_hs_n;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 13'h0AA; cmd_wdata = 32'h55AA55AA;
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!bready && n < 20) begin @(negedge clk); n++; end
    chk("abort reached WR_RESP", bready, 1);
    @(posedge clk); #2 reset = 1;
    #1;
    chk("abort flags", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_timeout, busy, cmd_ready},
        9'b000000001);
    chk("abort awaddr", awaddr, 13'h0);
    chk("abort wdata", wdata, 32'h0);
    chk("abort rsp_resp", rsp_resp, 2'b00);
    chk("abort state", dbg_state, 3'd0);
    @(negedge clk); @(negedge clk);
    s_b_dly = 0;
    @(posedge clk); #2 reset = 0;
    @(negedge clk); @(negedge clk);
    chk("abort no pending rsp", {rsp_valid, busy}, 2'b00);

    q_wr[0] = 1; q_addr[0] = 13'h200; q_data[0] = 32'h01010101;
    q_wr[1] = 0; q_addr[1] = 13'h204; q_data[1] = 32'hA0000001;
    q_wr[2] = 1; q_addr[2] = 13'h208; q_data[2] = 32'h02020202;
    q_wr[3] = 0; q_addr[3] = 13'h20C; q_data[3] = 32'hA0000003;
    q_wr[4] = 0; q_addr[4] = 13'h210; q_data[4] = 32'hA0000004;
    s_bresp = 2'b00; s_rresp = 2'b00;
    for (int i = 0; i < 5; i++) begin
      s_rdata = q_data[i];
      run_cmd(q_wr[i], q_addr[i], q_data[i], 0, $sformatf("seq%0d", i), rd, rs, to, lat);
      chk($sformatf("seq%0d rdata", i), rd, q_wr[i] ? 32'h0 : q_data[i]);
      chk($sformatf("seq%0d resp", i), {to, rs}, 3'b000);
      chk($sformatf("seq%0d addr", i), q_wr[i] ? snap_awaddr : snap_araddr, q_addr[i]);
      if (i == 0) chk("seq0 latency", lat, 3);
    end
    chk("seq B count", b_hs_n - b0, 2);
    chk("seq R count", r_hs_n - r0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
